ram_dp_be_clr: RTL and testbench

// Simple dual-port RAM for frame/line buffers: one write port, one read port, one clock.

---
 rtl/ram_dp_be_clr.sv | 136 +++++++++++++
 tb/tb_ram_dp_be_clr.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ram_dp_be_clr.sv
// ram_dp_be_clr: simple dual-port RAM with byte enables, 1/2-cycle read latency and a clear sequencer
module ram_dp_be_clr #(
   parameter int              DW       = 64,
   parameter int              WORDS    = 48,
   parameter int              ADDRW    = $clog2(WORDS),
   parameter int              BEW      = 8,
   parameter int              RD_LAT   = 1,
   parameter int              RDW_MODE = 0,
   parameter logic [DW-1:0]   CLR_VAL  = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_i,
   output logic               busy_o,
   input  logic               rd_en_i,
   input  logic [ADDRW-1:0]   rd_addr_i,
   output logic [DW-1:0]      rd_data_o,
   output logic               rd_valid_o,
   input  logic               wr_en_i,
   input  logic [DW/BEW-1:0]  wr_be_i,
   input  logic [ADDRW-1:0]   wr_addr_i,
   input  logic [DW-1:0]      wr_data_i
);
   localparam int NBE = DW / BEW;
   localparam logic [ADDRW-1:0] LAST    = ADDRW'(WORDS - 1);
   localparam logic [ADDRW:0]   WORDS_W = (ADDRW + 1)'(WORDS);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t           state_q, state_d;
   logic [ADDRW-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    mem_q [WORDS];
   logic             busy, wr_ok, rd_ok, rd_in, rdw;
   logic             mem_we;
   logic [ADDRW-1:0] mem_addr;
   logic [DW-1:0]    mem_mask, mem_wdata, wr_mask, rd_old, rd_word;
   logic             v1_q, v1_d;
   logic [DW-1:0]    d1_q, d1_d;

   assign busy   = state_q == CLEAR;
   assign busy_o = busy;

   // Clear sequencer: walk every address once after reset or a clear request
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            state_d = RUN;
            cnt_d   = '0;
         end
      end else if (clr_i) begin
         state_d = CLEAR;
         cnt_d   = '0;
      end
   end

   // State and clear counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Expand byte-lane enables into a bit mask
   always_comb begin
      wr_mask = '0;
      for (int i = 0; i < NBE; i++) wr_mask[i*BEW +: BEW] = {BEW{wr_be_i[i]}};
   end

   // Array write port: clear sequencer owns it while busy, user writes otherwise
   always_comb begin
      wr_ok     = !busy && wr_en_i && ({1'b0, wr_addr_i} < WORDS_W);
      mem_we    = !rst && (busy || (wr_ok && |wr_be_i));
      mem_addr  = busy ? cnt_q : wr_addr_i;
      mem_mask  = busy ? '1 : wr_mask;
      mem_wdata = busy ? CLR_VAL : wr_data_i;
   end

   // Masked array write; contents are initialised only by the clear sequence
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_addr] <= (mem_q[mem_addr] & ~mem_mask) | (mem_wdata & mem_mask);
   end

   // Read lookup with out-of-range substitution and optional write-forwarding
   always_comb begin
      rd_ok   = !busy && rd_en_i;
      rd_in   = {1'b0, rd_addr_i} < WORDS_W;
      rd_old  = rd_in ? mem_q[rd_addr_i] : CLR_VAL;
      rdw     = (RDW_MODE != 0) && wr_ok && (wr_addr_i == rd_addr_i);
      rd_word = rdw ? ((rd_old & ~wr_mask) | (wr_data_i & wr_mask)) : rd_old;
      v1_d    = rd_ok;
      d1_d    = rd_ok ? rd_word : d1_q;
   end

   // First read stage; data holds between reads
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q <= 1'b0;
         d1_q <= '0;
      end else begin
         v1_q <= v1_d;
         d1_q <= d1_d;
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic          v2_q, v2_d;
      logic [DW-1:0] d2_q, d2_d;
      // Extra output stage advances only on a valid first-stage result
      always_comb begin
         v2_d = v1_q;
         d2_d = v1_q ? d1_q : d2_q;
      end
      // Second read stage register
      always_ff @(posedge clk) begin
         if (rst) begin
            v2_q <= 1'b0;
            d2_q <= '0;
         end else begin
            v2_q <= v2_d;
            d2_q <= d2_d;
         end
      end
      assign rd_valid_o = v2_q;
      assign rd_data_o  = d2_q;
   end else begin : g_lat1
      assign rd_valid_o = v1_q;
      assign rd_data_o  = d1_q;
   end
endmodule

// File: tb/tb_ram_dp_be_clr.sv
// tb_ram_dp_be_clr: directed checks on two configurations sharing one stimulus stream
module tb_ram_dp_be_clr;
   localparam logic [63:0] CB = 64'hA5A5_A5A5_A5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst, clr, rd_en, wr_en;
   logic [5:0]  rd_addr, wr_addr;
   logic [7:0]  wr_be;
   logic [63:0] wr_data;
   logic        busy_a, valid_a, busy_b, valid_b;
   logic [63:0] data_a, data_b;
   int          checks = 0, errors = 0;
   int          na, nb, sv;

   always #5 clk = ~clk;

   ram_dp_be_clr #(.DW(64), .WORDS(48), .BEW(8), .RD_LAT(1), .RDW_MODE(0), .CLR_VAL(64'h0)) u_a (
      .clk(clk), .rst(rst), .clr_i(clr), .busy_o(busy_a),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(data_a), .rd_valid_o(valid_a),
      .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr), .wr_data_i(wr_data));

   ram_dp_be_clr #(.DW(64), .WORDS(50), .BEW(8), .RD_LAT(2), .RDW_MODE(1), .CLR_VAL(CB)) u_b (
      .clk(clk), .rst(rst), .clr_i(clr), .busy_o(busy_b),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(data_b), .rd_valid_o(valid_b),
      .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr), .wr_data_i(wr_data));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [5:0] a, input logic [63:0] d, input logic [7:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      step();
      wr_en = 1'b0;
   endtask

   task automatic rd2(input string tag, input logic [5:0] a, input logic [63:0] ea, input logic [63:0] eb);
      rd_en = 1'b1; rd_addr = a;
      step();
      rd_en = 1'b0;
      chk({tag, "_va"}, 64'(valid_a), 64'd1);
      chk({tag, "_da"}, data_a, ea);
      chk({tag, "_vb0"}, 64'(valid_b), 64'd0);
      step();
      chk({tag, "_va0"}, 64'(valid_a), 64'd0);
      chk({tag, "_vb"}, 64'(valid_b), 64'd1);
      chk({tag, "_db"}, data_b, eb);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; rd_en = 1'b0; rd_addr = '0;
      wr_en = 1'b0; wr_be = '0; wr_addr = '0; wr_data = '0;
      step();
      chk("rst_busy_a", 64'(busy_a), 64'd1);
      chk("rst_busy_b", 64'(busy_b), 64'd1);
      chk("rst_valid_a", 64'(valid_a), 64'd0);
      chk("rst_valid_b", 64'(valid_b), 64'd0);
      chk("rst_data_a", data_a, 64'd0);
      chk("rst_data_b", data_b, 64'd0);
      rst = 1'b0;
      na = 0; nb = 0; sv = 0;
      for (int k = 0; k < 100 && (busy_a || busy_b); k++) begin
         na += int'(busy_a);
         nb += int'(busy_b);
         step();
         sv += int'(valid_a | valid_b);
      end
      chk("init_busy_len_a", 64'(na), 64'd48);
      chk("init_busy_len_b", 64'(nb), 64'd50);
      chk("init_no_valid", 64'(sv), 64'd0);
      rd2("clr_rd0", 6'd0, 64'h0, CB);
      rd2("clr_rd47", 6'd47, 64'h0, CB);

      wr(6'd5, 64'h1122_3344_5566_7788, 8'h0F);
      rd2("be_lo", 6'd5, 64'h0000_0000_5566_7788, 64'hA5A5_A5A5_5566_7788);
      wr(6'd5, 64'hAABB_CCDD_0000_0000, 8'hF0);
      rd2("be_hi", 6'd5, 64'hAABB_CCDD_5566_7788, 64'hAABB_CCDD_5566_7788);
      wr(6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
      rd2("be_none", 6'd5, 64'hAABB_CCDD_5566_7788, 64'hAABB_CCDD_5566_7788);

      wr(6'd9, 64'h1, 8'hFF);
      wr_en = 1'b1; wr_addr = 6'd9; wr_data = 64'h2; wr_be = 8'hFF;
      rd_en = 1'b1; rd_addr = 6'd9;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("rdw_va", 64'(valid_a), 64'd1);
      chk("rdw_old_a", data_a, 64'h1);
      step();
      chk("rdw_vb", 64'(valid_b), 64'd1);
      chk("rdw_new_b", data_b, 64'h2);
      rd2("rdw_after", 6'd9, 64'h2, 64'h2);

      for (int i = 0; i < 4; i++) wr(6'(i), 64'h100 + 64'(i), 8'hFF);
      for (int i = 0; i < 4; i++) begin
         rd_en = 1'b1; rd_addr = 6'(i);
         step();
         chk("pipe_va", 64'(valid_a), 64'd1);
         chk("pipe_da", data_a, 64'h100 + 64'(i));
         if (i == 0) chk("pipe_vb0", 64'(valid_b), 64'd0);
         else begin
            chk("pipe_vb", 64'(valid_b), 64'd1);
            chk("pipe_db", data_b, 64'h100 + 64'(i - 1));
         end
      end
      rd_en = 1'b0;
      step();
      chk("pipe_va_end", 64'(valid_a), 64'd0);
      chk("pipe_vb_last", 64'(valid_b), 64'd1);
      chk("pipe_db_last", data_b, 64'h103);
      step();
      chk("pipe_vb_end", 64'(valid_b), 64'd0);
      chk("pipe_db_hold", data_b, 64'h103);

      clr = 1'b1; rd_en = 1'b1; rd_addr = 6'd3;
      step();
      clr = 1'b0; rd_en = 1'b0;
      chk("clr_busy_a", 64'(busy_a), 64'd1);
      chk("clr_busy_b", 64'(busy_b), 64'd1);
      chk("clr_pre_va", 64'(valid_a), 64'd1);
      chk("clr_pre_da", data_a, 64'h103);
      wr_en = 1'b1; wr_addr = 6'd3; wr_data = 64'hDEAD; wr_be = 8'hFF;
      rd_en = 1'b1; rd_addr = 6'd3;
      na = 1; nb = 1; sv = 0;
      step();
      chk("clr_pre_vb", 64'(valid_b), 64'd1);
      chk("clr_pre_db", data_b, 64'h103);
      chk("clr_va0", 64'(valid_a), 64'd0);
      for (int k = 0; k < 100 && (busy_a || busy_b); k++) begin
         na += int'(busy_a);
         nb += int'(busy_b);
         step();
         sv += int'(valid_a | valid_b);
         if (!busy_a) begin
            wr_en = 1'b0; rd_en = 1'b0;
         end
      end
      wr_en = 1'b0; rd_en = 1'b0;
      chk("clr_len_a", 64'(na), 64'd48);
      chk("clr_len_b", 64'(nb), 64'd50);
      chk("clr_no_valid", 64'(sv), 64'd0);
      rd2("clr_addr3", 6'd3, 64'h0, CB);
      rd2("clr_addr5", 6'd5, 64'h0, CB);

      wr(6'd50, 64'hFF, 8'hFF);
      rd2("oor_rd50", 6'd50, 64'h0, CB);
      rd2("oor_rd49", 6'd49, 64'h0, CB);
      rd2("oor_rd2", 6'd2, 64'h0, CB);

      rd_en = 1'b1; rd_addr = 6'd50;
      step();
      rd_en = 1'b0;
      chk("rstrd_va", 64'(valid_a), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstrd_vb", 64'(valid_b), 64'd0);
      chk("rstrd_db", data_b, 64'h0);
      chk("rstrd_va0", 64'(valid_a), 64'd0);
      chk("rstrd_busy_b", 64'(busy_b), 64'd1);
      step();
      chk("rstrd_vb_after", 64'(valid_b), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
